// File: rtl/lector_rom_7seg_pkg.sv
// Shared definitions for the ROM reader / 7-segment display driver:
// FSM state encodings, the blank segment pattern and default timing.
package lector_rom_7seg_pkg;

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        LEER    = 3'd1,
        ESPERA  = 3'd2,
        CAPTURA = 3'd3,
        MOSTRAR = 3'd4,
        FIN     = 3'd5
    } estado_t;

    // All segments off (active low).
    localparam logic [6:0] SEG_BLANCO = 7'b1111111;
    // Pattern for "0", also the display state out of reset.
    localparam logic [6:0] SEG_CERO   = 7'b1000000;

    localparam int T_MUESTRA_DEF  = 50_000_000;
    localparam int T_REFRESCO_DEF = 50_000;

    // Active-low one-hot anode for the selected digit.
    function automatic logic [3:0] anodo_activo(input logic [1:0] sel);
        anodo_activo = ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/lector_rom_7seg_decodificador.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module decodificador_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup; every input value maps to a glyph.
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/lector_rom_7seg.sv
// Sequential ROM reader: walks the ROM once per start pulse, accumulates
// the byte sum and shows each byte on a multiplexed 4-digit display.
//
// state   | meaning
// --------+-------------------------------------------------------------
// REPOSO  | idle, waits for inicio; display keeps last byte / address
// LEER    | drive the current index onto rom_dir
// ESPERA  | one settle cycle for the combinational ROM
// CAPTURA | register the byte, add it to suma, load the display timer
// MOSTRAR | hold the byte for T_MUESTRA cycles, then next index or FIN
// FIN     | one-cycle completion pulse, back to REPOSO
module lector_rom_7seg
    import lector_rom_7seg_pkg::*;
#(
    parameter int DIR_W       = 4,
    parameter int DATO_W      = 8,
    parameter int PROFUNDIDAD = 8,
    parameter int T_MUESTRA   = T_MUESTRA_DEF,
    parameter int T_REFRESCO  = T_REFRESCO_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inicio,
    output logic [DIR_W-1:0]  rom_dir,
    input  logic [DATO_W-1:0] rom_dato,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [DATO_W+2:0] suma,
    output logic              ocupado,
    output logic              fin
);

    localparam int CNT_W = (T_MUESTRA > 1) ? $clog2(T_MUESTRA) : 1;
    localparam int REF_W = (T_REFRESCO > 1) ? $clog2(T_REFRESCO) : 1;

    localparam logic [CNT_W-1:0] CNT_CARGA  = CNT_W'(T_MUESTRA - 1);
    localparam logic [REF_W-1:0] REF_CARGA  = REF_W'(T_REFRESCO - 1);
    localparam logic [DIR_W-1:0] INDICE_ULT = DIR_W'(PROFUNDIDAD - 1);

    estado_t           estado;
    logic [DIR_W-1:0]  indice;
    logic [DATO_W-1:0] dato_reg;
    logic [CNT_W-1:0]  cnt_muestra;

    logic [REF_W-1:0]  cnt_refresco;
    logic [1:0]        digito_sel;
    logic [3:0]        nibble;
    logic [6:0]        seg_hex;
    logic [6:0]        seg_sig;

    // Read sequencer: all FSM outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado      <= REPOSO;
            rom_dir     <= '0;
            indice      <= '0;
            dato_reg    <= '0;
            suma        <= '0;
            cnt_muestra <= '0;
            ocupado     <= 1'b0;
            fin         <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        indice  <= '0;
                        suma    <= '0;
                        ocupado <= 1'b1;
                        estado  <= LEER;
                    end
                end
                LEER: begin
                    rom_dir <= indice;
                    estado  <= ESPERA;
                end
                ESPERA: begin
                    estado <= CAPTURA;
                end
                CAPTURA: begin
                    dato_reg    <= rom_dato;
                    suma        <= suma + {3'b000, rom_dato};
                    cnt_muestra <= CNT_CARGA;
                    estado      <= MOSTRAR;
                end
                MOSTRAR: begin
                    if (cnt_muestra == '0) begin
                        if (indice == INDICE_ULT) begin
                            estado <= FIN;
                        end else begin
                            indice <= indice + 1'b1;
                            estado <= LEER;
                        end
                    end else begin
                        cnt_muestra <= cnt_muestra - 1'b1;
                    end
                end
                FIN: begin
                    fin     <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
                default: begin
                    estado  <= REPOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    // Free-running digit scan timer, independent of the sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_refresco <= '0;
            digito_sel   <= 2'd0;
        end else if (cnt_refresco == '0) begin
            cnt_refresco <= REF_CARGA;
            digito_sel   <= digito_sel + 2'd1;
        end else begin
            cnt_refresco <= cnt_refresco - 1'b1;
        end
    end

    // Pick the nibble shown on the currently selected digit.
    always_comb begin
        nibble = 4'h0;
        case (digito_sel)
            2'd0:    nibble = dato_reg[3:0];
            2'd1:    nibble = dato_reg[7:4];
            2'd3:    nibble = 4'(rom_dir);
            default: nibble = 4'h0;
        endcase
    end

    decodificador_7seg u_deco (
        .hex (nibble),
        .seg (seg_hex)
    );

    // Digit 2 is always blank.
    always_comb begin
        seg_sig = (digito_sel == 2'd2) ? SEG_BLANCO : seg_hex;
    end

    // Anode and segments are registered together so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= 4'b1110;
            seg <= SEG_CERO;
        end else begin
            an  <= anodo_activo(digito_sel);
            seg <= seg_sig;
        end
    end

endmodule
